// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_pkg
// Description : Shared encodings and default widths for the 101 sequence
//               detector frame controller and its detector datapath.
//               - ctrl_state_e : controller FSM (IDLE, LOAD, SHIFT, DONE)
//               - det_state_e  : Moore 101 detector states (S0..S3)
//               - DEF_*        : default DATA_W / LEN_W / CNT_W
// Revision    : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_LEN_W  = 8;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } ctrl_state_e;

  typedef enum logic [1:0] {
    DET_S0 = 2'd0,
    DET_S1 = 2'd1,
    DET_S2 = 2'd2,
    DET_S3 = 2'd3
  } det_state_e;

endpackage
`default_nettype wire

// File: rtl/det101_en.sv
`default_nettype none
// ============================================================================
// Module      : det101_en
// Description : Moore-type overlapping "101" detector with enable and
//               synchronous clear. State only advances while en is high, so
//               a pattern may straddle gaps in the serial stream.
// Ports       : clk   - clock, rising edge
//               reset - synchronous active-high reset (state -> S0)
//               clr   - synchronous clear (state -> S0)
//               en    - advance the detector this cycle
//               xin   - serial input bit
//               y     - high while in S3 (registered Moore output)
// Revision    : 1.0 - initial release
// ============================================================================
module det101_en
  import seq_det_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic xin,
  output logic y
);

  det_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (en) begin
      case (state_q)
        DET_S0:  state_d = xin ? DET_S1 : DET_S0;
        DET_S1:  state_d = xin ? DET_S1 : DET_S2;
        DET_S2:  state_d = xin ? DET_S3 : DET_S0;
        DET_S3:  state_d = xin ? DET_S1 : DET_S2;
        default: state_d = DET_S0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      state_q <= DET_S0;
    end else begin
      state_q <= state_d;
    end
  end

  assign y = (state_q == DET_S3);

endmodule
`default_nettype wire

// File: rtl/seq_det_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_ctrl
// Description : Frame controller for a bit-serial 101 detector. Accepts
//               frame_len words over a valid/ready handshake, serializes each
//               MSB-first into det101_en and counts overlapping matches
//               (saturating). Pulses done for one cycle at end of frame.
// Ports       : clk, reset          - clock / synchronous active-high reset
//               start, frame_len    - begin frame (sampled in IDLE), length
//               in_valid, in_data   - producer word
//               in_ready            - high in LOAD
//               busy                - high outside IDLE
//               bit_out             - serial bit into the detector
//               det                 - detector output (state S3)
//               match_cnt           - match count of current / last frame
//               done                - one-cycle end-of-frame pulse
// Revision    : 1.0 - initial release
// ============================================================================
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              bit_out,
  output logic              det,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              done
);

  localparam int                 IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

  ctrl_state_e        state_q, state_d;
  logic [DATA_W-1:0]  sr_q,    sr_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [LEN_W-1:0]   rem_q,   rem_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [1:0]         hist_q,  hist_d;

  logic w_start_acc;
  logic w_shift;
  logic w_bit;
  logic w_hit;

  assign w_start_acc = (state_q == ST_IDLE) && start;
  assign w_shift     = (state_q == ST_SHIFT);
  assign w_bit       = w_shift ? sr_q[DATA_W-1] : 1'b0;

  // The detector sits in S2 exactly when the last two enabled bits since the
  // last clear were 1 then 0, so a 1 arriving now moves it into S3. Tracking
  // those two bits locally gives the "next state is S3" condition on the same
  // edge without widening the detector's port list.
  assign w_hit = w_shift && w_bit && (hist_q == 2'b10);

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    hist_d  = hist_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rem_d   = frame_len;
          cnt_d   = '0;
          hist_d  = 2'b00;
          state_d = (frame_len == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          sr_d    = in_data;
          idx_d   = '0;
          rem_d   = rem_q - LEN_W'(1);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sr_d   = sr_q << 1;
        idx_d  = idx_q + IDX_W'(1);
        hist_d = {hist_q[0], w_bit};
        if (w_hit && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (idx_q == LAST_IDX) begin
          state_d = (rem_q != '0) ? ST_LOAD : ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      idx_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      hist_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      hist_q  <= hist_d;
    end
  end

  det101_en u_det (
    .clk   (clk),
    .reset (reset),
    .clr   (w_start_acc),
    .en    (w_shift),
    .xin   (w_bit),
    .y     (det)
  );

  assign in_ready  = (state_q == ST_LOAD);
  assign busy      = (state_q != ST_IDLE);
  assign bit_out   = w_bit;
  assign match_cnt = cnt_q;
  assign done      = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_seq_det_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_det_ctrl
// Description : Self-checking bench for seq_det_ctrl. Table of frames with
//               hand-computed done cycle, match counts, per-cycle det and
//               bit_out masks and LOAD-cycle counts, plus hand-written
//               reset sequences. A second instance with CNT_W=2 shares the
//               stimulus to exercise counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_det_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] frame_len;
  logic       in_valid;
  logic [7:0] in_data;

  logic       in_ready, busy, bit_out, det, done;
  logic [7:0] match_cnt;
  logic       in_ready2, busy2, bit_out2, det2, done2;
  logic [1:0] match_cnt2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_det_ctrl #(.DATA_W(8), .LEN_W(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .frame_len(frame_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .busy(busy), .bit_out(bit_out), .det(det), .match_cnt(match_cnt),
    .done(done)
  );

  seq_det_ctrl #(.DATA_W(8), .LEN_W(8), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .frame_len(frame_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2),
    .busy(busy2), .bit_out(bit_out2), .det(det2), .match_cnt(match_cnt2),
    .done(done2)
  );

  typedef struct {
    string      name;
    logic [7:0] len;
    logic [7:0] w0;
    logic [7:0] w1;
    int         stall;     // LOAD cycles with in_valid low before word 1
    int         ign;       // cycle at which a stray start is pulsed (0: none)
    int         exp_done;  // cycle in which done is high
    logic [7:0] exp_cnt;
    logic [1:0] exp_cnt2;  // CNT_W=2 instance
    logic [31:0] exp_det;  // bit k = det high in cycle k
    logic [31:0] exp_bit;  // bit k = bit_out high in cycle k
    int         exp_rdy;   // number of cycles with in_ready high
  } vec_t;

  vec_t vecs[5];

  function automatic vec_t mk(input string nm, input logic [7:0] len,
                              input logic [7:0] w0, input logic [7:0] w1,
                              input int stall, input int ign, input int exp_done,
                              input logic [7:0] exp_cnt, input logic [1:0] exp_cnt2,
                              input logic [31:0] exp_det, input logic [31:0] exp_bit,
                              input int exp_rdy);
    vec_t v;
    v.name = nm; v.len = len; v.w0 = w0; v.w1 = w1; v.stall = stall; v.ign = ign;
    v.exp_done = exp_done; v.exp_cnt = exp_cnt; v.exp_cnt2 = exp_cnt2;
    v.exp_det = exp_det; v.exp_bit = exp_bit; v.exp_rdy = exp_rdy;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run_frame(input vec_t v);
    logic [31:0] detm, bitm;
    logic [7:0]  words[2];
    logic [7:0]  c1;
    logic [1:0]  c2;
    logic        stray;
    int          rdy, done_k, wi, stl;
    words[0] = v.w0; words[1] = v.w1;
    detm = '0; bitm = '0; c1 = '0; c2 = '0; stray = 1'b0;
    rdy = 0; done_k = -1; wi = 0; stl = 0;

    // cycle 0: start sampled at the following rising edge
    @(negedge clk);
    start = 1'b1; frame_len = v.len; in_valid = 1'b0;
    for (int k = 1; k < 200; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == v.ign) begin
        start = 1'b1;
        frame_len = 8'd3;
      end
      if (k < 32) begin
        detm[k] = det;
        bitm[k] = bit_out;
      end
      if (in_ready) rdy++;
      if (done) begin
        done_k = k;
        c1 = match_cnt;
        c2 = match_cnt2;
        break;
      end
      in_valid = 1'b0;
      if (in_ready && (wi < int'(v.len))) begin
        if (wi > 0 && stl < v.stall) begin
          stl++;
        end else begin
          in_valid = 1'b1;
          in_data  = words[wi];
          wi++;
        end
      end
    end
    in_valid = 1'b0;

    check({v.name, " done_cycle"}, done_k, v.exp_done);
    check({v.name, " match_cnt"},  {24'd0, c1}, {24'd0, v.exp_cnt});
    check({v.name, " match_cnt_sat"}, {30'd0, c2}, {30'd0, v.exp_cnt2});
    check({v.name, " det_mask"},   detm, v.exp_det);
    check({v.name, " bit_out_mask"}, bitm, v.exp_bit);
    check({v.name, " ready_cycles"}, rdy, v.exp_rdy);

    // After DONE the controller must sit idle with the count held.
    repeat (3) begin
      @(negedge clk);
      stray = stray | busy | done;
    end
    check({v.name, " idle_after_done"}, {31'd0, stray}, 32'd0);
    check({v.name, " cnt_held"}, {24'd0, match_cnt}, {24'd0, v.exp_cnt});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; frame_len = '0; in_valid = 1'b0; in_data = '0;

    vecs[0] = mk("a5_stray_start", 8'd1, 8'hA5, 8'h00, 0, 4, 10, 8'd2, 2'd2,
                 32'h0000_0420, 32'h0000_0294, 1);
    vecs[1] = mk("aa_overlap", 8'd1, 8'hAA, 8'h00, 0, 0, 10, 8'd3, 2'd3,
                 32'h0000_02A0, 32'h0000_0154, 1);
    vecs[2] = mk("cross_word_stall", 8'd2, 8'h01, 8'h40, 5, 0, 24, 8'd1, 2'd1,
                 32'h0004_0000, 32'h0002_0200, 7);
    vecs[3] = mk("len_zero", 8'd0, 8'h00, 8'h00, 0, 0, 1, 8'd0, 2'd0,
                 32'h0000_0000, 32'h0000_0000, 0);
    vecs[4] = mk("aa_aa_saturate", 8'd2, 8'hAA, 8'hAA, 0, 0, 19, 8'd7, 2'd3,
                 32'h0005_52A0, 32'h0002_A954, 2);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {24'd0, in_ready, busy, bit_out, det, done, 3'd0},
          32'd0);
    check("reset_match_cnt", {22'd0, match_cnt, match_cnt2}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i]);
    end

    // Reset in the middle of SHIFT of an A5 frame.
    @(negedge clk);                     // cycle 0
    start = 1'b1; frame_len = 8'd1; in_valid = 1'b1; in_data = 8'hA5;
    @(negedge clk);                     // cycle 1 (LOAD, word accepted)
    start = 1'b0;
    @(negedge clk);                     // cycle 2
    in_valid = 1'b0;
    repeat (4) @(negedge clk);          // cycle 6
    check("pre_reset_state", {22'd0, busy, match_cnt, in_ready}, {22'd0, 1'b1, 8'd1, 1'b0});
    reset = 1'b1;
    @(negedge clk);
    check("midframe_reset_outputs",
          {19'd0, in_ready, busy, bit_out, det, done, match_cnt},
          32'd0);
    check("midframe_reset_sat_cnt", {30'd0, match_cnt2}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_idle", {30'd0, busy, done}, 32'd0);

    run_frame(mk("a5_after_reset", 8'd1, 8'hA5, 8'h00, 0, 0, 10, 8'd2, 2'd2,
                 32'h0000_0420, 32'h0000_0294, 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
